// File: rtl/rst_seq_pkg.sv
// Shared types and sizing helpers for the reset sequencer.
package rst_seq_pkg;

    typedef enum logic [2:0] {
        RESET,
        HOLD,
        RELEASE,
        RUN,
        ACK
    } rst_seq_state_e;

    // Counter must hold the larger of the two terminal values.
    function automatic int count_width(input int hold, input int gap);
        int m;
        m = (hold > gap) ? hold : gap;
        return $clog2(m + 1);
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rst_sync.sv
// Async-assert / sync-deassert reset synchronizer chain.
module rst_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic arst_ni,
    output logic rel_o,   // last stage goes high on the next edge
    output logic sync_o   // synchronized reset release
);

    logic [STAGES-1:0] chain_q;
    logic [STAGES-1:0] chain_d;

    always_comb begin
        chain_d = {chain_q[STAGES-2:0], 1'b1};
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) chain_q <= '0;
        else          chain_q <= chain_d;
    end

    assign sync_o = chain_q[STAGES-1];
    assign rel_o  = chain_q[STAGES-2];

endmodule

// File: rtl/rst_seq.sv
// Reset sequencer: synchronized release, hold period, staggered domain
// release and a four-phase software reset handshake.
module rst_seq
    import rst_seq_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int NUM_OUT     = 3,
    parameter int STAGE_GAP   = 4
) (
    input  logic               clk_i,
    input  logic               arst_ni,
    input  logic               sw_rst_req_i,
    output logic               sw_rst_ack_o,
    output logic [NUM_OUT-1:0] rst_no,
    output logic               rst_done_o
);

    localparam int CW = count_width(HOLD_CYCLES, STAGE_GAP);
    localparam int IW = idx_width(NUM_OUT);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'(STAGE_GAP - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_OUT - 1);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("rst_seq: SYNC_STAGES must be >= 2");
    end
    if (HOLD_CYCLES < 1 || STAGE_GAP < 1 || NUM_OUT < 1) begin : g_bad_param
        $error("rst_seq: HOLD_CYCLES, STAGE_GAP and NUM_OUT must be >= 1");
    end

    logic rel;
    logic sync;

    rst_sync #(
        .STAGES (SYNC_STAGES)
    ) u_rst_sync (
        .clk_i   (clk_i),
        .arst_ni (arst_ni),
        .rel_o   (rel),
        .sync_o  (sync)
    );

    rst_seq_state_e     state_q, state_d;
    logic [CW-1:0]      cnt_q,   cnt_d;
    logic [IW-1:0]      idx_q,   idx_d;
    logic [NUM_OUT-1:0] rst_q,   rst_d;
    logic               done_q,  done_d;
    logic               ack_q,   ack_d;
    logic               pend_q,  pend_d;
    logic               fin;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rst_d   = rst_q;
        done_d  = done_q;
        ack_d   = ack_q;
        pend_d  = pend_q;
        fin     = 1'b0;

        case (state_q)
            // Enter HOLD on the edge where the chain output rises, so the
            // hold count lines up with the synchronized release edge.
            RESET: begin
                if (rel && !sync) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LOAD;
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    rst_d[0] = 1'b1;
                    idx_d    = '0;
                    if (NUM_OUT == 1) begin
                        fin = 1'b1;
                    end else begin
                        state_d = RELEASE;
                        cnt_d   = GAP_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RELEASE: begin
                if (cnt_q == '0) begin
                    idx_d = IW'(idx_q + 1'b1);
                    for (int k = 0; k < NUM_OUT; k++) begin
                        if (IW'(k) == idx_d) rst_d[k] = 1'b1;
                    end
                    if (idx_d == LAST_IDX) fin = 1'b1;
                    else                   cnt_d = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RUN: begin
                if (sw_rst_req_i) begin
                    rst_d   = '0;
                    done_d  = 1'b0;
                    pend_d  = 1'b1;
                    cnt_d   = HOLD_LOAD;
                    state_d = HOLD;
                end
            end
            ACK: begin
                if (!sw_rst_req_i) begin
                    ack_d   = 1'b0;
                    state_d = RUN;
                end
            end
            default: state_d = RESET;
        endcase

        // Last domain released: report done, and acknowledge if this
        // sequence was started by software.
        if (fin) begin
            done_d  = 1'b1;
            ack_d   = pend_q;
            pend_d  = 1'b0;
            state_d = pend_q ? ACK : RUN;
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q <= RESET;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_q   <= '0;
            done_q  <= 1'b0;
            ack_q   <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rst_q   <= rst_d;
            done_q  <= done_d;
            ack_q   <= ack_d;
            pend_q  <= pend_d;
        end
    end

    assign rst_no       = rst_q;
    assign rst_done_o   = done_q;
    assign sw_rst_ack_o = ack_q;

endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq: default instance plus a NUM_OUT=1, HOLD=1 instance.
module tb_rst_seq;

    logic       clk_i = 1'b0;
    logic       arst_ni;
    logic       sw_rst_req_i;
    logic       ack;
    logic [2:0] rst_n;
    logic       done;
    logic       ack1;
    logic [0:0] rst1_n;
    logic       done1;

    int n_chk = 0;
    int n_err = 0;
    int cur   = 0;
    int e;

    always #5 clk_i = ~clk_i;

    rst_seq u_dut (
        .clk_i        (clk_i),
        .arst_ni      (arst_ni),
        .sw_rst_req_i (sw_rst_req_i),
        .sw_rst_ack_o (ack),
        .rst_no       (rst_n),
        .rst_done_o   (done)
    );

    rst_seq #(
        .SYNC_STAGES (2),
        .HOLD_CYCLES (1),
        .NUM_OUT     (1),
        .STAGE_GAP   (4)
    ) u_dut1 (
        .clk_i        (clk_i),
        .arst_ni      (arst_ni),
        .sw_rst_req_i (sw_rst_req_i),
        .sw_rst_ack_o (ack1),
        .rst_no       (rst1_n),
        .rst_done_o   (done1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h (edge %0d)", tag, got, exp, cur);
        end
    endtask

    // Advance to 1 ns after edge n of the current sequence.
    task automatic to_edge(input int n);
        repeat (n - cur) @(posedge clk_i);
        #1;
        cur = n;
    endtask

    task automatic power_cycle();
        arst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        arst_ni = 1'b1;
        cur = 0;
    endtask

    initial begin
        arst_ni      = 1'b0;
        sw_rst_req_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_rst_n", 32'(rst_n), 32'h0);
        chk("rst_done",  32'(done),  32'h0);
        chk("rst_ack",   32'(ack),   32'h0);
        chk("rst_rst1",  32'(rst1_n), 32'h0);

        // power-up with defaults
        arst_ni = 1'b1;
        cur = 0;
        to_edge(2);  chk("n1_e2_rst", 32'(rst1_n), 32'h0);
        to_edge(3);  chk("n1_e3_rst", 32'(rst1_n), 32'h1);
                     chk("n1_e3_done", 32'(done1), 32'h1);
        to_edge(17); chk("pu_e17", 32'(rst_n), 32'h0);
        to_edge(18); chk("pu_e18", 32'(rst_n), 32'h1);
        to_edge(21); chk("pu_e21", 32'(rst_n), 32'h1);
        to_edge(22); chk("pu_e22", 32'(rst_n), 32'h3);
        to_edge(25); chk("pu_e25", 32'(rst_n), 32'h3);
                     chk("pu_e25_done", 32'(done), 32'h0);
        to_edge(26); chk("pu_e26", 32'(rst_n), 32'h7);
                     chk("pu_e26_done", 32'(done), 32'h1);
                     chk("pu_e26_ack", 32'(ack), 32'h0);

        // short arst glitch mid-RELEASE restarts the sequence
        power_cycle();
        to_edge(21); chk("gl_pre", 32'(rst_n), 32'h1);
        arst_ni = 1'b0;
        #1;
        chk("gl_rst_n", 32'(rst_n), 32'h0);
        chk("gl_done",  32'(done),  32'h0);
        #2;
        arst_ni = 1'b1;
        cur = 0;
        to_edge(17); chk("gl_e17", 32'(rst_n), 32'h0);
        to_edge(18); chk("gl_e18", 32'(rst_n), 32'h1);
        to_edge(26); chk("gl_e26", 32'(rst_n), 32'h7);
                     chk("gl_e26_done", 32'(done), 32'h1);

        // software reset, request held until E+30
        to_edge(30);
        sw_rst_req_i = 1'b1;
        e = cur + 1;
        to_edge(e);      chk("sw_E_rst", 32'(rst_n), 32'h0);
                         chk("sw_E_done", 32'(done), 32'h0);
                         chk("n1_sw_E", 32'(rst1_n), 32'h0);
        to_edge(e + 1);  chk("n1_sw_ack", 32'(ack1), 32'h1);
                         chk("n1_sw_rst", 32'(rst1_n), 32'h1);
        to_edge(e + 15); chk("sw_E15", 32'(rst_n), 32'h0);
        to_edge(e + 16); chk("sw_E16", 32'(rst_n), 32'h1);
        to_edge(e + 20); chk("sw_E20", 32'(rst_n), 32'h3);
        to_edge(e + 23); chk("sw_E23_ack", 32'(ack), 32'h0);
        to_edge(e + 24); chk("sw_E24", 32'(rst_n), 32'h7);
                         chk("sw_E24_done", 32'(done), 32'h1);
                         chk("sw_E24_ack", 32'(ack), 32'h1);
        to_edge(e + 29); chk("sw_E29_ack", 32'(ack), 32'h1);
        sw_rst_req_i = 1'b0;
        to_edge(e + 30); chk("sw_E30_ack", 32'(ack), 32'h0);
                         chk("sw_E30_rst", 32'(rst_n), 32'h7);

        // one-cycle pulse: ack high for exactly one cycle
        to_edge(e + 32);
        sw_rst_req_i = 1'b1;
        e = cur + 1;
        to_edge(e);
        sw_rst_req_i = 1'b0;
        chk("pl_E_rst", 32'(rst_n), 32'h0);
        to_edge(e + 23); chk("pl_E23_ack", 32'(ack), 32'h0);
        to_edge(e + 24); chk("pl_E24_ack", 32'(ack), 32'h1);
                         chk("pl_E24_rst", 32'(rst_n), 32'h7);
        to_edge(e + 25); chk("pl_E25_ack", 32'(ack), 32'h0);
                         chk("pl_E25_done", 32'(done), 32'h1);

        // request held in ACK must not retrigger
        to_edge(e + 27);
        sw_rst_req_i = 1'b1;
        e = cur + 1;
        to_edge(e + 24); chk("hd_E24_ack", 32'(ack), 32'h1);
        to_edge(e + 74); chk("hd_E74_ack", 32'(ack), 32'h1);
                         chk("hd_E74_rst", 32'(rst_n), 32'h7);
                         chk("hd_E74_done", 32'(done), 32'h1);
        sw_rst_req_i = 1'b0;
        to_edge(e + 75); chk("hd_E75_ack", 32'(ack), 32'h0);
                         chk("hd_E75_rst", 32'(rst_n), 32'h7);

        // request during HOLD is ignored
        power_cycle();
        to_edge(5);
        sw_rst_req_i = 1'b1;
        to_edge(10);
        sw_rst_req_i = 1'b0;
        to_edge(17); chk("ih_e17", 32'(rst_n), 32'h0);
        to_edge(18); chk("ih_e18", 32'(rst_n), 32'h1);
        to_edge(26); chk("ih_e26", 32'(rst_n), 32'h7);
                     chk("ih_e26_ack", 32'(ack), 32'h0);
        to_edge(27); chk("ih_e27_ack", 32'(ack), 32'h0);
                     chk("ih_e27_rst", 32'(rst_n), 32'h7);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
